alu_dispatch: RTL and testbench
===============================

# alu_dispatch

Command front end of the TinyALU. Accepts one command at a time (opcode plus two 8-bit operands) and executes add, and, and xor internally in one cycle. Multiplies are forwarded to the `three_cycle` multiplier through a held start/done handshake, and each command returns one registered 16-bit result with a one-cycle `done` pulse.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: maximum number of cycles spent in MUL_WAIT before an abort. Range 2..255. Used only when the timeout feature is compiled in.

Ports:
- `clk`  in  1  Single clock. All logic is rising-edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Command request. The requester holds it high until it sees `done`.
- `op`  in  3  Opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul. 101–111 are reserved and treated as no_op.
- `A`, `B`  in  8 each  Operands. Sampled only at the accept edge.
- `done`  out  1  One-cycle pulse marking that `result` is valid.
- `result`  out  16  Registered result. Holds its value until the next completion.
- `busy`  out  1  High from the accept edge until the edge that ends `done`.
- `err`  out  1  Multiply-timeout flag, driven alongside `done`. Tied to 0 when the timeout feature is not compiled in.
- `mul_start`  out  1  Registered request to `three_cycle`.
- `mul_a`, `mul_b`  out  8 each  Registered operands to the multiplier. Stable while `mul_start` is high.
- `mul_done`  in  1  Multiplier completion.
- `mul_result`  in  16  Multiplier product. Valid while `mul_done` is high.

## Operation
States: IDLE, MUL_WAIT, RESP.
- **IDLE, accept:** a command is accepted when `start` is high and `armed` is 1. `armed` is an internal flag, set by reset and by any edge that samples `start` low in IDLE.
- **Single-cycle ops (add/and/xor/no_op/reserved):**
  - At the accept edge: register the result, set `done`=1, set `busy`=1, go to RESP.
  - add: `{7'b0, A+B}`, with the 9-bit carry kept in bit 8.
  - and / xor: `{8'b0, A&B}` / `{8'b0, A^B}`.
  - no_op and reserved: `result` is unchanged, `done` still pulses.
- **mul:**
  - At the accept edge: latch `mul_a`=A and `mul_b`=B, set `mul_start`=1, go to MUL_WAIT.
- **MUL_WAIT:**
  - At the first edge that samples `mul_done`=1: set `result`=`mul_result`, clear `mul_start`, set `done`=1, go to RESP.
- **RESP:**
  - Next edge: clear `done`, clear `busy`, clear `armed`, go to IDLE.
  - The held `start` is therefore never re-accepted as a new command.
- **`start` while busy:** ignored. `op`, `A` and `B` changes are ignored outside the accept edge.
- **`mul_done` outside MUL_WAIT:** ignored. It has no effect on `result` or `done`.
- **Reset mid-operation:** all state returns to reset values immediately. An in-flight multiply is dropped, and a late `mul_done` from it is ignored.

## Timing
- **Reset values:**
  - `done`=0, `result`=0, `busy`=0, `err`=0.
  - `mul_start`=0, `mul_a`=0, `mul_b`=0.
  - state=IDLE, `armed`=1.
- **Single-cycle op latency:** `done` is high in the cycle after the accept edge.
- **Multiply latency:** `done` is high one cycle after the first cycle in which `mul_done` is high.
  - With `three_cycle`, `mul_done` rises 4 edges after `mul_start` is first sampled.
  - So accept → `done` high is 6 cycles.
- **Back-to-back commands:** the requester drops `start` in the cycle after `done`. A new command is accepted no earlier than 2 cycles after `done`.
- **`mul_start`:** high continuously from the accept edge through the edge that samples `mul_done`. It is never re-pulsed within a command.

## Configuration
- **`ALU_DISPATCH_TIMEOUT_EN` defined:**
  - A cycle counter runs in MUL_WAIT.
  - If `TIMEOUT_CYCLES` edges pass without `mul_done`: clear `mul_start`, set `result`=16'h0000, set `err`=1 and `done`=1 together for one cycle, go to RESP.
  - `err` clears with `done`.
  - `mul_done` arriving on the timeout edge itself wins: normal completion, `err`=0.
- **Not defined:** no counter. MUL_WAIT waits indefinitely, and `err` is constant 0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-multiply.
  - Immediately: all outputs go to their reset values.
  - After release: a late `mul_done` pulse produces no `done`.
- **Add:** op=001, A=8'hFF, B=8'h01, `start` held.
  - `done` for one cycle, 1 cycle after accept, with `result`=16'h0100.
  - No second accept while `start` stays high.
- **xor then and, back-to-back:** op=011 with A=8'hF0, B=8'h3C, then op=010 with A=8'hF0, B=8'h3C.
  - `result` 16'h00CC, then 16'h0030.
  - Second accept occurs 2 cycles after the first `done`.
- **Multiply with a real `three_cycle`:** op=100, A=8'hFF, B=8'hFF.
  - `mul_start` high for 5 cycles.
  - `done` 6 cycles after accept, with `result`=16'hFE01, `err`=0.
- **Ignored inputs:** no_op with `result` previously 16'h1234 → `done` pulses, `result` stays 16'h1234. `start` with op=001 while in MUL_WAIT → ignored.
- **Timeout (`ALU_DISPATCH_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=15):** `mul_done` tied low.
  - `done`=1, `err`=1, `result`=0 after 15 cycles in MUL_WAIT.
  - `mul_start` low afterwards.

Source files
------------

// File: rtl/alu_dispatch.sv
// alu_dispatch: TinyALU command front end. add/and/xor complete in one cycle, mul is handed
// to the three_cycle multiplier. Optional multiply timeout enabled by ALU_DISPATCH_TIMEOUT_EN.
//
// state      | meaning
// S_IDLE     | waiting for a command; start must be seen low once before the next accept
// S_MUL_WAIT | mul_start held high, waiting for mul_done (or timeout)
// S_RESP     | done pulse cycle, then back to idle
module alu_dispatch #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        done,
  output logic [15:0] result,
  output logic        busy,
  output logic        err,
  output logic        mul_start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic        mul_done,
  input  logic [15:0] mul_result
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_RESP     = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("alu_dispatch: TIMEOUT_CYCLES must be in 2..255");
  end

  state_t      r_state, w_state_nxt;
  logic        r_armed, w_armed_nxt;
  logic        r_done, w_done_nxt;
  logic [15:0] r_result, w_result_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_mul_start, w_mul_start_nxt;
  logic [7:0]  r_mul_a, w_mul_a_nxt;
  logic [7:0]  r_mul_b, w_mul_b_nxt;
  logic [8:0]  w_sum;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_to_cnt, w_to_cnt_nxt;
  logic       r_err, w_err_nxt;
`endif

  assign w_sum = {1'b0, A} + {1'b0, B};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_armed_nxt     = r_armed;
    w_done_nxt      = r_done;
    w_result_nxt    = r_result;
    w_busy_nxt      = r_busy;
    w_mul_start_nxt = r_mul_start;
    w_mul_a_nxt     = r_mul_a;
    w_mul_b_nxt     = r_mul_b;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    w_to_cnt_nxt    = r_to_cnt;
    w_err_nxt       = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (start && r_armed) begin
          w_busy_nxt = 1'b1;
          if (op == OP_MUL) begin
            w_mul_a_nxt     = A;
            w_mul_b_nxt     = B;
            w_mul_start_nxt = 1'b1;
            w_state_nxt     = S_MUL_WAIT;
`ifdef ALU_DISPATCH_TIMEOUT_EN
            w_to_cnt_nxt    = TO_LOAD;
`endif
          end else begin
            case (op)
              OP_ADD:  w_result_nxt = {7'b0, w_sum};
              OP_AND:  w_result_nxt = {8'b0, A & B};
              OP_XOR:  w_result_nxt = {8'b0, A ^ B};
              default: w_result_nxt = r_result;
            endcase
            w_done_nxt  = 1'b1;
            w_state_nxt = S_RESP;
          end
        end else if (!start) begin
          w_armed_nxt = 1'b1;
        end
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
          w_result_nxt    = mul_result;
          w_mul_start_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_state_nxt     = S_RESP;
        end
`ifdef ALU_DISPATCH_TIMEOUT_EN
        // mul_done on the terminal-count edge takes priority over the abort
        else if (r_to_cnt == 8'd0) begin
          w_result_nxt    = 16'h0000;
          w_mul_start_nxt = 1'b0;
          w_done_nxt      = 1'b1;
          w_err_nxt       = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_to_cnt_nxt = r_to_cnt - 8'd1;
        end
`endif
      end
      S_RESP: begin
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        w_armed_nxt = 1'b0;
        w_state_nxt = S_IDLE;
`ifdef ALU_DISPATCH_TIMEOUT_EN
        w_err_nxt   = 1'b0;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b1;
      r_done      <= 1'b0;
      r_result    <= 16'h0000;
      r_busy      <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_a     <= 8'h00;
      r_mul_b     <= 8'h00;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      r_to_cnt    <= 8'h00;
      r_err       <= 1'b0;
`endif
    end else begin
      r_armed     <= w_armed_nxt;
      r_done      <= w_done_nxt;
      r_result    <= w_result_nxt;
      r_busy      <= w_busy_nxt;
      r_mul_start <= w_mul_start_nxt;
      r_mul_a     <= w_mul_a_nxt;
      r_mul_b     <= w_mul_b_nxt;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      r_to_cnt    <= w_to_cnt_nxt;
      r_err       <= w_err_nxt;
`endif
    end
  end

  assign done      = r_done;
  assign result    = r_result;
  assign busy      = r_busy;
  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed self-checking bench for alu_dispatch, with a behavioural three_cycle multiplier.
// Timeout section runs only when ALU_DISPATCH_TIMEOUT_EN is defined.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        done, busy, err, mul_start;
  logic [15:0] result;
  logic [7:0]  mul_a, mul_b;

  logic        use_model = 1'b0;
  logic        man_done = 1'b0;
  logic [15:0] man_result = 16'h0000;
  logic        m_done, m_fired;
  logic [1:0]  m_cnt;
  logic [15:0] m_res;
  wire         w_mul_done   = use_model ? m_done : man_done;
  wire  [15:0] w_mul_result = use_model ? m_res : man_result;

  int n_checks = 0;
  int n_errors = 0;

  alu_dispatch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .A          (a),
    .B          (b),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .err        (err),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (w_mul_done),
    .mul_result (w_mul_result)
  );

  always #5 clk = ~clk;

  // three_cycle: mul_done pulses after the 4th edge that samples mul_start high
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0; m_fired <= 1'b0; m_cnt <= 2'd0; m_res <= 16'h0000;
    end else if (mul_start && !m_fired) begin
      if (m_cnt == 2'd3) begin
        m_done <= 1'b1; m_fired <= 1'b1; m_res <= 16'(mul_a) * 16'(mul_b);
      end else begin
        m_cnt <= m_cnt + 2'd1;
      end
    end else begin
      m_done <= 1'b0;
      if (!mul_start) begin
        m_fired <= 1'b0; m_cnt <= 2'd0;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ms_cnt, done_at, n_done;

    // reset values
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_done", 16'(done), 16'h0);
    check("rst_result", result, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_mul_start", 16'(mul_start), 16'h0);
    check("rst_mul_ab", {mul_a, mul_b}, 16'h0000);
    rst_n = 1'b1;
    tick();

    // add with carry, start held: single done, no re-accept
    op = 3'b001; a = 8'hFF; b = 8'h01; start = 1'b1;
    tick();
    check("add_done", 16'(done), 16'h1);
    check("add_result", result, 16'h0100);
    check("add_busy", 16'(busy), 16'h1);
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("add_no_reaccept", 16'(n_done), 16'h0);
    start = 1'b0;
    tick();

    // xor then and back-to-back
    op = 3'b011; a = 8'hF0; b = 8'h3C; start = 1'b1;
    tick();
    check("xor_done", 16'(done), 16'h1);
    check("xor_result", result, 16'h00CC);
    tick();
    check("xor_done_end", 16'(done), 16'h0);
    start = 1'b0; op = 3'b010;
    tick();
    check("b2b_not_yet", 16'({done, busy}), 16'h0);
    start = 1'b1;
    tick();
    check("and_done", 16'(done), 16'h1);
    check("and_result", result, 16'h0030);
    tick();
    start = 1'b0;
    tick();

    // multiply through three_cycle; op/A/B changes mid-wait are ignored
    use_model = 1'b1;
    op = 3'b100; a = 8'hFF; b = 8'hFF; start = 1'b1;
    ms_cnt = 0; done_at = 0;
    for (int i = 1; i <= 20 && done_at == 0; i++) begin
      tick();
      if (mul_start) ms_cnt++;
      if (i == 1) check("mul_operands", {mul_a, mul_b}, 16'hFFFF);
      if (i == 2) begin op = 3'b001; a = 8'h01; b = 8'h02; end
      if (done) begin
        done_at = i;
        check("mul_result", result, 16'hFE01);
        check("mul_err", 16'(err), 16'h0);
        check("mul_start_cleared", 16'(mul_start), 16'h0);
      end
    end
    check("mul_latency", 16'(done_at), 16'd6);
    check("mul_start_len", 16'(ms_cnt), 16'd5);
    tick();
    check("mul_resp_end", 16'({done, busy}), 16'h0);
    start = 1'b0; use_model = 1'b0;
    tick();

    // manual multiply to plant 1234, then stray mul_done outside MUL_WAIT
    op = 3'b100; a = 8'h01; b = 8'h02; start = 1'b1;
    tick(); tick();
    man_done = 1'b1; man_result = 16'h1234;
    tick();
    check("man_mul_done", 16'(done), 16'h1);
    check("man_mul_result", result, 16'h1234);
    man_result = 16'hBEEF;
    tick();
    check("stray_resp", result, 16'h1234);
    start = 1'b0;
    tick();
    check("stray_idle_done", 16'(done), 16'h0);
    check("stray_idle_result", result, 16'h1234);
    man_done = 1'b0;
    tick();

    // no_op and reserved opcode keep result but pulse done
    op = 3'b000; start = 1'b1;
    tick();
    check("noop_done", 16'(done), 16'h1);
    check("noop_result", result, 16'h1234);
    tick();
    start = 1'b0;
    tick();
    op = 3'b111; a = 8'h55; b = 8'h0F; start = 1'b1;
    tick();
    check("rsvd_done", 16'(done), 16'h1);
    check("rsvd_result", result, 16'h1234);
    tick();
    start = 1'b0;
    tick();

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // timeout with mul_done tied low
    op = 3'b100; a = 8'h07; b = 8'h09; start = 1'b1;
    done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      tick();
      if (done) begin
        done_at = i;
        check("to_err", 16'(err), 16'h1);
        check("to_result", result, 16'h0000);
        check("to_mul_start", 16'(mul_start), 16'h0);
      end
    end
    check("to_latency", 16'(done_at), 16'd16);
    tick();
    check("to_err_clear", 16'({err, done, mul_start}), 16'h0);
    start = 1'b0;
    tick();
    op = 3'b100; a = 8'h03; b = 8'h05; start = 1'b1;
    tick(); tick(); tick(); tick();
`else
    // no timeout: MUL_WAIT holds indefinitely
    op = 3'b100; a = 8'h03; b = 8'h05; start = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done) n_done++;
    end
    check("wait_no_done", 16'(n_done), 16'h0);
    check("wait_busy", 16'({busy, mul_start, err}), 16'b110);
`endif

    // asynchronous reset mid-multiply, then a late mul_done is ignored
    check("pre_rst_mul_start", 16'(mul_start), 16'h1);
    rst_n = 1'b0; start = 1'b0;
    #1;
    check("arst_outputs", 16'({done, busy, err, mul_start}), 16'h0);
    check("arst_result", result, 16'h0000);
    check("arst_mul_ab", {mul_a, mul_b}, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    man_done = 1'b1; man_result = 16'hABCD;
    tick();
    man_done = 1'b0;
    check("late_done", 16'({done, busy}), 16'h0);
    check("late_result", result, 16'h0000);
    tick();
    check("late_done2", 16'(done), 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
